// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type and frame constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
    localparam int DATA_BITS = 8;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: count-based synchronous FIFO with show-ahead head and overflow pulse
module uart_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr_ok, rd_ok;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            wr_ptr <= wr_ok ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd_ok ? rd_ptr + 1'b1 : rd_ptr;
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
        end
    end
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr] <= wr_data;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8-bit UART serializer with optional parity
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BIT = 434,
    parameter int TICKS_PER_BIT_SIZE = 9,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_wr_en,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_overflow,
    output logic                          o_dout,
    output logic                          o_busy,
    output logic                          o_done
);
    uart_tx_state_t state;
    logic [TICKS_PER_BIT_SIZE-1:0] tick;
    logic [2:0] idx;
    logic [7:0] sh, head;
    logic last_tick, pop;
    assign last_tick = tick == TICKS_PER_BIT_SIZE'(TICKS_PER_BIT - 1);
    assign pop = !o_empty && (state == IDLE || (state == STOP && last_tick));
    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk(i_clk),
        .rst(i_rst),
        .wr_en(i_wr_en),
        .wr_data(i_wr_data),
        .rd_en(pop),
        .rd_data(head),
        .full(o_full),
        .empty(o_empty),
        .count(o_count),
        .overflow(o_overflow)
    );
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            tick <= '0;
            idx <= '0;
            sh <= '0;
            o_dout <= STOP_BIT;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            tick <= last_tick ? '0 : tick + 1'b1;
            case (state)
                IDLE: begin
                    tick <= '0;
                    if (pop) begin
                        sh <= head;
                        state <= START;
                        o_dout <= START_BIT;
                        o_busy <= 1'b1;
                    end
                end
                START: if (last_tick) begin
                    state <= DATA;
                    idx <= '0;
                    o_dout <= sh[0];
                end
                DATA: if (last_tick) begin
                    if (idx == 3'(DATA_BITS - 1)) begin
                        state <= PARITY_EN != 0 ? PARITY : STOP;
                        o_dout <= PARITY_EN != 0 ? (^sh) ^ (PARITY_ODD != 0) : STOP_BIT;
                    end else begin
                        idx <= idx + 3'd1;
                        o_dout <= sh[idx + 3'd1];
                    end
                end
                PARITY: if (last_tick) begin
                    state <= STOP;
                    o_dout <= STOP_BIT;
                end
                STOP: if (last_tick) begin
                    o_done <= 1'b1;
                    if (pop) begin
                        sh <= head;
                        state <= START;
                        o_dout <= START_BIT;
                    end else begin
                        state <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
